// File: rtl/iob_iobuf_bank.sv
// W-bit registered bidirectional pad bank: per-bit drive FSM with turnaround guard,
// registered output data, input synchroniser, per-bit inversion and edge pulses.
module iob_iobuf_bank #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i,
    input  logic [W-1:0] t,
    input  logic [W-1:0] n,
    output logic [W-1:0] o,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall,
    output logic [W-1:0] busy,
    inout  wire  [W-1:0] io
);

    typedef enum logic [1:0] {
        S_HIZ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [3:0] TURN_LOAD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    logic [W-1:0] i_q;
    logic [W-1:0] drv;
    logic [W-1:0] pad_in;
    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] sync_last;
    logic [W-1:0] prev;

    for (genvar k = 0; k < W; k++) begin : g_bit
        state_t     st;
        logic [3:0] cnt;
        logic       drv_r;

        // drv_r rises one edge after DRIVE is entered, but drops on the very edge t is seen high.
        always_ff @(posedge clk) begin
            if (rst) begin
                st    <= S_HIZ;
                cnt   <= 4'd0;
                drv_r <= 1'b0;
            end else begin
                drv_r <= (st == S_DRIVE) && !t[k];
                case (st)
                    S_HIZ: begin
                        if (!t[k]) begin
                            if (TURN_CYCLES == 0) begin
                                st <= S_DRIVE;
                            end else begin
                                st  <= S_WAIT;
                                cnt <= TURN_LOAD;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (t[k]) begin
                            st <= S_HIZ;
                        end else if (cnt == 4'd0) begin
                            st <= S_DRIVE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_DRIVE: begin
                        if (t[k]) begin
                            st <= S_HIZ;
                        end
                    end
                    default: st <= S_HIZ;
                endcase
            end
        end

        assign drv[k]  = drv_r;
        assign busy[k] = (st == S_WAIT);

`ifdef XILINX
        IOBUF u_iobuf (
            .I (i_q[k]),
            .T (~drv_r),
            .O (pad_in[k]),
            .IO(io[k])
        );
`else
        assign io[k]     = drv_r ? i_q[k] : 1'bz;
        assign pad_in[k] = io[k];
`endif
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Edge detection runs on the synchronised pad value, before inversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            prev   <= '0;
            o_rise <= '0;
            o_fall <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            i_q       <= i;
            sync_q[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev   <= sync_last;
            o_rise <= sync_last & ~prev;
            o_fall <= ~sync_last & prev;
        end
    end

    assign o = n ^ sync_last;

endmodule
